// File: rtl/rx_pingpong_packer.sv
// Multi-channel I/Q packer: serialises one sample set per strobe into a
// two-page ping-pong sample RAM, with page hand-off, hold and overrun counting.
module rx_pingpong_packer #(
  parameter int CH      = 2,
  parameter int IQ_W    = 24,
  parameter int DEPTH   = 256,
  parameter int PAGE_AW = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [CH*IQ_W-1:0]   in_i,
  input  logic [CH*IQ_W-1:0]   in_q,
  input  logic                 rd_done,
  input  logic                 rd_page,
  output logic [2*IQ_W-1:0]    ram_wr_data,
  output logic [PAGE_AW:0]     ram_wr_addr,
  output logic                 ram_wen,
  output logic                 page_ready,
  output logic                 page_block,
  output logic [1:0]           pending,
  output logic [7:0]           overrun_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, BURST, HOLD} state_t;

  localparam int CW = $clog2(CH + 1);
  localparam logic [CW-1:0]      CH_L     = CW'(CH);
  localparam logic [PAGE_AW-1:0] LAST_IDX = PAGE_AW'(DEPTH - 1);

  state_t                state_q, state_d;
  logic                  wpage_q, wpage_d;
  logic [PAGE_AW-1:0]    widx_q, widx_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [CH*IQ_W-1:0]    i_lat_q, i_lat_d;
  logic [CH*IQ_W-1:0]    q_lat_q, q_lat_d;
  logic [2*IQ_W-1:0]     ram_wr_data_q, ram_wr_data_d;
  logic [PAGE_AW:0]      ram_wr_addr_q, ram_wr_addr_d;
  logic                  ram_wen_q, ram_wen_d;
  logic                  page_ready_q, page_ready_d;
  logic                  page_block_q, page_block_d;
  logic [1:0]            pending_q, pending_d;
  logic [7:0]            overrun_q, overrun_d;
  logic                  busy_q, busy_d;
  logic                  en_prev_q, en_prev_d;

  logic [CH*IQ_W-1:0]    src_i, src_q;
  logic [CW-1:0]         sel_ch;
  logic [2*IQ_W-1:0]     word;
  logic                  drop;
  logic                  nxt_page;

  always_comb begin
    state_d       = state_q;
    wpage_d       = wpage_q;
    widx_d        = widx_q;
    ch_d          = ch_q;
    i_lat_d       = i_lat_q;
    q_lat_d       = q_lat_q;
    ram_wr_data_d = ram_wr_data_q;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wen_d     = 1'b0;
    page_ready_d  = 1'b0;
    page_block_d  = page_block_q;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    en_prev_d     = enable;
    drop          = 1'b0;
    nxt_page      = ~wpage_q;

    // Channel 0 is written straight from the inputs on the accept cycle;
    // later channels come from the latched copy.
    src_i  = (state_q == IDLE) ? in_i : i_lat_q;
    src_q  = (state_q == IDLE) ? in_q : q_lat_q;
    sel_ch = (state_q == IDLE) ? '0 : ch_q;
    word   = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (sel_ch == CW'(k)) begin
        word = {src_i[k*IQ_W +: IQ_W], src_q[k*IQ_W +: IQ_W]};
      end
    end

    pending_d = pending_q;
    if (rd_done) begin
      pending_d[rd_page] = 1'b0;
    end

    if (!enable) begin
      state_d   = IDLE;
      wpage_d   = 1'b0;
      widx_d    = '0;
      ch_d      = '0;
      pending_d = '0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            i_lat_d       = in_i;
            q_lat_d       = in_q;
            ram_wen_d     = 1'b1;
            ram_wr_data_d = word;
            ram_wr_addr_d = {wpage_q, widx_q};
            widx_d        = (widx_q == LAST_IDX) ? '0 : widx_q + PAGE_AW'(1);
            ch_d          = CW'(1);
            busy_d        = 1'b1;
            state_d       = BURST;
          end
        end
        BURST: begin
          drop = in_valid;
          if (ch_q < CH_L) begin
            ram_wen_d     = 1'b1;
            ram_wr_data_d = word;
            ram_wr_addr_d = {wpage_q, widx_q};
            widx_d        = (widx_q == LAST_IDX) ? '0 : widx_q + PAGE_AW'(1);
            ch_d          = ch_q + CW'(1);
          end else begin
            ch_d   = '0;
            busy_d = 1'b0;
            // widx back at 0 after the last write means this page is full
            if (widx_q == '0) begin
              pending_d[wpage_q] = 1'b1;
              page_block_d       = wpage_q;
              page_ready_d       = 1'b1;
              wpage_d            = nxt_page;
              state_d            = pending_d[nxt_page] ? HOLD : IDLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        HOLD: begin
          drop = in_valid;
          if (!pending_q[wpage_q]) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (enable && !en_prev_q) begin
      overrun_d = '0;
    end else if (drop && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      wpage_q       <= 1'b0;
      widx_q        <= '0;
      ch_q          <= '0;
      i_lat_q       <= '0;
      q_lat_q       <= '0;
      ram_wr_data_q <= '0;
      ram_wr_addr_q <= '0;
      ram_wen_q     <= 1'b0;
      page_ready_q  <= 1'b0;
      page_block_q  <= 1'b0;
      pending_q     <= '0;
      overrun_q     <= '0;
      busy_q        <= 1'b0;
      en_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wpage_q       <= wpage_d;
      widx_q        <= widx_d;
      ch_q          <= ch_d;
      i_lat_q       <= i_lat_d;
      q_lat_q       <= q_lat_d;
      ram_wr_data_q <= ram_wr_data_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wen_q     <= ram_wen_d;
      page_ready_q  <= page_ready_d;
      page_block_q  <= page_block_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
      en_prev_q     <= en_prev_d;
    end
  end

  assign ram_wr_data = ram_wr_data_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wen     = ram_wen_q;
  assign page_ready  = page_ready_q;
  assign page_block  = page_block_q;
  assign pending     = pending_q;
  assign overrun_cnt = overrun_q;
  assign busy        = busy_q;

endmodule

// File: doc/rx_pingpong_packer.md
Name: rx_pingpong_packer

Overview:
- Multi-channel successor to the receiver-to-USB sample path.
- Takes one decimated I/Q sample per channel on each `in_valid` strobe and serialises the channels into one-word-per-cycle RAM writes.
- Writes into a two-page (ping-pong) dual-port sample RAM. Signals each completed page to the USB reader and tracks which pages the reader still holds.
- Adds back-pressure accounting the single-channel path lacks: page hold, drop and saturating overrun count.

Parameters:
- `CH`, default 2: number of receiver channels, 1..8.
- `IQ_W`, default 24: bits per I and per Q sample; RAM word is 2*IQ_W.
- `DEPTH`, default 256: words per page; power of two and an integer multiple of `CH`.
- `PAGE_AW`, default 8: clog2(DEPTH), address bits within a page.

Ports:
- `clock` in 1: sample-domain clock (76.8 MHz in the current build).
- `reset` in 1: synchronous, active-high.
- `enable` in 1: receiver on. Low holds the block idle and rewinds it.
- `in_valid` in 1: single-cycle strobe; all channel samples are valid.
- `in_i` in CH*IQ_W: channel k I sample in bits [k*IQ_W +: IQ_W].
- `in_q` in CH*IQ_W: channel k Q sample, same packing as `in_i`.
- `rd_done` in 1: single-cycle pulse from the reader (already synchronised into `clock`); releases page `rd_page`.
- `rd_page` in 1: page released by `rd_done`.
- `ram_wr_data` out 2*IQ_W: {I, Q} of the current channel, I in the upper half.
- `ram_wr_addr` out PAGE_AW+1: {page, word index}.
- `ram_wen` out 1: write enable, one word per cycle.
- `page_ready` out 1: single-cycle pulse; a page has just been completed.
- `page_block` out 1: index of the most recently completed page.
- `pending` out 2: bit p is set while page p is full and not yet released.
- `overrun_cnt` out 8: saturating count of dropped sample sets.
- `busy` out 1: a burst is in progress.

Behaviour:
- Reset values: every output is 0. The state machine is IDLE, the write page is 0 and the word index is 0.
- States: IDLE, BURST, HOLD.
  - IDLE, `enable` high and `in_valid`: latch `in_i`/`in_q`, go to BURST. `busy` goes to 1 on the next cycle.
  - BURST: on each cycle k = 0..CH-1, drive `ram_wen`=1, `ram_wr_data` = {I_k, Q_k} and `ram_wr_addr` = {wpage, widx}, then increment `widx`.
    - Latency: the first write occurs 1 cycle after the accepted `in_valid`; the burst lasts exactly CH cycles.
  - End of burst, `widx` did not wrap: return to IDLE.
  - End of burst, `widx` wrapped to 0 (page full):
    - set `pending[wpage]` and `page_block` <= `wpage`;
    - pulse `page_ready` on the cycle after the last write;
    - toggle `wpage`;
    - if `pending` of the new `wpage` is already set, go to HOLD, otherwise go to IDLE.
  - HOLD: no writes. Leave HOLD, back to IDLE, on the cycle after `pending[wpage]` clears.
- Drops:
  - Any `in_valid` arriving in BURST or HOLD is discarded and increments `overrun_cnt`.
  - `overrun_cnt` saturates at 255 and clears only on reset or on the rising edge of `enable`.
- `rd_done`:
  - Clears `pending[rd_page]` on the next clock edge.
  - If a page-full set and `rd_done` hit the same bit in the same cycle, the set wins.
  - A release of a page that is not pending is ignored.
- `enable` low (including mid-burst or in HOLD):
  - the next cycle goes to IDLE with `ram_wen`=0;
  - `wpage`, `widx` and `pending` return to 0;
  - `page_block` holds its value;
  - no `page_ready` pulse is issued for the partial page.
- Width rules:
  - samples are stored verbatim, with no rounding or sign change;
  - `widx` wraps modulo DEPTH;
  - because DEPTH is a multiple of CH, a burst never straddles two pages.
- Sizing: the `in_valid` spacing must be at least CH+1 cycles. Closer spacing is not an error; it produces a counted drop.

Test Plan:
- Reset: CH=2, IQ_W=24, DEPTH=256; assert `reset` for 2 cycles with `enable`=1 → all outputs 0; first `in_valid` writes address 0x000, then 0x001.
- Packing: `in_i` = {24'hBBBBBB, 24'hAAAAAA}, `in_q` = {24'h222222, 24'h111111}, one strobe → `ram_wr_data` 48'hAAAAAA111111 @0x000, then 48'hBBBBBB222222 @0x001; `ram_wen` high for exactly 2 cycles.
- Page turn: 128 strobes spaced 4 cycles → last write @0x0FF; `page_ready` pulses once; `page_block`=0; `pending`=2'b01; next write @0x100.
- Hold and overrun: no `rd_done`, 256 strobes → `pending`=2'b11, state HOLD; 10 more strobes → `overrun_cnt`=10 and no writes. Then `rd_done` with `rd_page`=0 → `pending`=2'b10; next strobe writes @0x000.
- Collision: strobes spaced 2 cycles → every other strobe dropped; after 600 drops `overrun_cnt` stays at 255. An `enable` low→high edge clears it to 0.
- Abort: drop `enable` during the second write of a burst at `widx`=0x7F → `ram_wen`=0 next cycle, no `page_ready`, `pending`=0; after re-enable the first write goes to @0x000.
